// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer with one-shot/periodic modes and a maskable interrupt
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d;
    logic             irq_flag_q, irq_flag_d;
    logic [31:0]      preset_w, count_w, preset_m;
    logic             wr_ctrl, wr_preset, one_shot, unused_ok;
    assign preset_w  = 32'(preset_q);
    assign count_w   = 32'(count_q);
    assign wr_ctrl   = |byteen && addr[3:2] == 2'd0;
    assign wr_preset = |byteen && addr[3:2] == 2'd1;
    assign one_shot  = ctrl_q[2:1] != 2'b01;
    assign irq       = irq_flag_q & ctrl_q[3] & ~reset;
    assign unused_ok = &{1'b0, addr[31:4], addr[1:0]};
    // byte-lane merge of the write data into the current PRESET value
    always_comb begin
        for (int i = 0; i < 4; i++) preset_m[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : preset_w[8*i +: 8];
    end
    // read mux; unmapped offset and upper CTRL bits read as zero
    always_comb begin
        rdata = addr[3:2] == 2'd0 ? {28'd0, ctrl_q} :
                addr[3:2] == 2'd1 ? preset_w :
                addr[3:2] == 2'd2 ? count_w : 32'd0;
    end
    // next state: FSM first, then CPU writes override CTRL; the FSM's flag set beats a write's flag clear
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;
        if ((wr_ctrl || wr_preset) && one_shot) irq_flag_d = 1'b0;
        case (state_q)
            IDLE: if (ctrl_q[0]) state_d = LOAD;
            LOAD: begin
                state_d = ctrl_q[0] ? CNT : IDLE;
                count_d = ctrl_q[0] ? preset_q : count_q;
            end
            CNT: begin
                if (!ctrl_q[0]) state_d = IDLE;
                else if (count_q > WIDTH'(1)) count_d = count_q - WIDTH'(1);
                else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                state_d = IDLE;
                if (one_shot) ctrl_d[0] = 1'b0;
                else irq_flag_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];
        if (wr_preset) preset_d = WIDTH'(preset_m);
    end
    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for the countdown timer peripheral
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    int          tests = 0;
    int          fails = 0;

    timer_counter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        tick();
        byteen = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; byteen = 4'h0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 32'h0; byteen = 4'h0; wdata = 32'h0;
        tick();
        chk("irq_in_reset", irq, 0);
        tick();
        reset = 1'b0;
        // reset values and CTRL width
        rd("rst_ctrl", 32'h0, 32'h0);
        rd("rst_preset", 32'h4, 32'h0);
        rd("rst_count", 32'h8, 32'h0);
        rd("rst_0xc", 32'hC, 32'h0);
        chk("rst_irq", irq, 0);
        wr(32'h0, 4'hF, 32'hFFFF_FFFF);
        rd("ctrl_mask", 32'h0, 32'h0000_000F);
        do_reset();
        // one-shot, PRESET=5
        wr(32'h4, 4'hF, 32'd5);
        wr(32'h0, 4'hF, 32'h9);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            rd("os_count", 32'h8, 32'(5 - k));
            chk("os_irq_low", irq, 0);
            tick();
        end
        rd("os_int_count", 32'h8, 32'h0);
        chk("os_irq_rise", irq, 1);
        tick();
        rd("os_ctrl_en_clr", 32'h0, 32'h8);
        chk("os_irq_hold", irq, 1);
        tick();
        chk("os_irq_hold2", irq, 1);
        reset = 1'b1;
        #1;
        chk("irq_comb_reset", irq, 0);
        reset = 1'b0;
        #1;
        chk("irq_after_glitch", irq, 1);
        wr(32'h4, 4'hF, 32'd7);
        chk("os_preset_clr", irq, 0);
        // periodic, PRESET=3: INT, IDLE, LOAD and 3 CNT cycles per period
        do_reset();
        wr(32'h4, 4'hF, 32'd3);
        wr(32'h0, 4'hF, 32'hB);
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk($sformatf("per_irq_%0d", k), irq, 32'(k >= 5 && (k - 5) % 6 == 0));
        end
        rd("per_ctrl", 32'h0, 32'hB);
        // reset mid-count in periodic mode
        do_reset();
        wr(32'h4, 4'hF, 32'd6);
        wr(32'h0, 4'hF, 32'hB);
        repeat (4) tick();
        rd("mid_count4", 32'h8, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("mid_rst_count", 32'h8, 32'h0);
        rd("mid_rst_ctrl", 32'h0, 32'h0);
        chk("mid_rst_irq", irq, 0);
        tick();
        rd("mid_rst_count2", 32'h8, 32'h0);
        // one-shot stopped mid-count, then reloaded
        do_reset();
        wr(32'h4, 4'hF, 32'd10);
        wr(32'h0, 4'hF, 32'h9);
        repeat (5) tick();
        rd("stop_count7", 32'h8, 32'd7);
        wr(32'h0, 4'hF, 32'h8);
        rd("stop_count6", 32'h8, 32'd6);
        tick();
        rd("stop_hold", 32'h8, 32'd6);
        chk("stop_state_idle", 32'(dut.state_q), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            rd("stop_hold_n", 32'h8, 32'd6);
            chk("stop_irq_low", irq, 0);
        end
        wr(32'h0, 4'hF, 32'h9);
        tick();
        rd("reload_load", 32'h8, 32'd6);
        tick();
        rd("reload_count", 32'h8, 32'd10);
        // masked interrupt, then CTRL write clears the flag
        do_reset();
        wr(32'h4, 4'hF, 32'd2);
        wr(32'h0, 4'hF, 32'h1);
        repeat (4) tick();
        chk("mask_irq", irq, 0);
        chk("mask_flag", 32'(dut.irq_flag_q), 32'd1);
        tick();
        rd("mask_ctrl", 32'h0, 32'h0);
        chk("mask_flag_hold", 32'(dut.irq_flag_q), 32'd1);
        wr(32'h0, 4'hF, 32'h8);
        chk("im_set_flag_clr", 32'(dut.irq_flag_q), 32'd0);
        chk("im_set_irq", irq, 0);
        tick();
        chk("im_set_irq2", irq, 0);
        // byte-lane writes and ignored offsets
        do_reset();
        wr(32'h4, 4'hF, 32'h1234_5678);
        rd("preset_full", 32'h4, 32'h1234_5678);
        wr(32'h4, 4'h1, 32'h0000_00AB);
        rd("preset_byte0", 32'h4, 32'h1234_56AB);
        wr(32'h4, 4'h4, 32'h00CD_0000);
        rd("preset_byte2", 32'h4, 32'h12CD_56AB);
        wr(32'h8, 4'hF, 32'h55);
        rd("count_ro", 32'h8, 32'h0);
        wr(32'hC, 4'hF, 32'hFF);
        rd("reg_0xc", 32'hC, 32'h0);
        rd("preset_keep", 32'h4, 32'h12CD_56AB);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
